// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that maps 6502-style arithmetic/logic requests onto an
// external 8-bit combinational ALU, including two-pass 16-bit address math.
module alu_sequencer #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SR  = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b010,
  parameter logic [2:0] ALU_OR  = 3'b011,
  parameter logic [2:0] ALU_XOR = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_c,
  input  logic        req_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_n,
  output logic        rsp_z,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_wb,
  output logic        rsp_err,
  output logic [2:0]  alu_control,
  output logic [7:0]  alu_AI,
  output logic [7:0]  alu_BI,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_Y,
  input  logic        alu_carry_out
);

  localparam logic [3:0] OP_ADC   = 4'h0;
  localparam logic [3:0] OP_SBC   = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_ORA   = 4'h4;
  localparam logic [3:0] OP_EOR   = 4'h5;
  localparam logic [3:0] OP_ASL   = 4'h6;
  localparam logic [3:0] OP_LSR   = 4'h7;
  localparam logic [3:0] OP_ROL   = 4'h8;
  localparam logic [3:0] OP_ROR   = 4'h9;
  localparam logic [3:0] OP_INC   = 4'hA;
  localparam logic [3:0] OP_DEC   = 4'hB;
  localparam logic [3:0] OP_ADD16 = 4'hC;
  localparam logic [3:0] OP_INC16 = 4'hD;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  op_reg;
  logic [15:0] a_reg, b_reg;
  logic        c_reg, v_reg;
  logic [7:0]  lo_reg;
  logic        carry_lo_reg;
  logic        is16, illegal_req, v_calc;
  logic        carry_flag, ovf_flag;

  assign is16        = (op_reg == OP_ADD16) || (op_reg == OP_INC16);
  assign illegal_req = (req_op == 4'hE) || (req_op == 4'hF);
  assign req_ready   = (state_reg == IDLE);
  assign rsp_valid   = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = illegal_req ? DONE : LO;
      LO:   state_next = is16 ? HI : DONE;
      HI:   state_next = DONE;
      DONE: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU is idle-parked on ADD with zero operands outside the compute passes.
  always_comb begin
    alu_control  = ALU_ADD;
    alu_AI       = 8'h00;
    alu_BI       = 8'h00;
    alu_carry_in = 1'b0;
    if (state_reg == LO) begin
      alu_AI = a_reg[7:0];
      case (op_reg)
        OP_ADC:   begin alu_BI = b_reg[7:0];  alu_carry_in = c_reg; end
        OP_SBC:   begin alu_BI = ~b_reg[7:0]; alu_carry_in = c_reg; end
        OP_CMP:   begin alu_BI = ~b_reg[7:0]; alu_carry_in = 1'b1;  end
        OP_AND:   begin alu_BI = b_reg[7:0];  alu_control = ALU_AND; end
        OP_ORA:   begin alu_BI = b_reg[7:0];  alu_control = ALU_OR;  end
        OP_EOR:   begin alu_BI = b_reg[7:0];  alu_control = ALU_XOR; end
        OP_ASL:   alu_BI = a_reg[7:0];
        OP_ROL:   begin alu_BI = a_reg[7:0];  alu_carry_in = c_reg; end
        OP_LSR:   alu_control = ALU_SR;
        OP_ROR:   begin alu_control = ALU_SR; alu_carry_in = c_reg; end
        OP_INC:   alu_carry_in = 1'b1;
        OP_DEC:   alu_BI = 8'hFF;
        OP_ADD16: alu_BI = b_reg[7:0];
        OP_INC16: alu_carry_in = 1'b1;
        default:  alu_AI = 8'h00;
      endcase
    end else if (state_reg == HI) begin
      alu_AI       = a_reg[15:8];
      alu_BI       = (op_reg == OP_ADD16) ? b_reg[15:8] : 8'h00;
      alu_carry_in = carry_lo_reg;
    end
  end

  // Signed overflow from the operands actually presented on the final pass.
  assign v_calc = (alu_AI[7] ~^ alu_BI[7]) & (alu_AI[7] ^ alu_Y[7]);

  always_comb begin
    carry_flag = c_reg;
    ovf_flag   = v_reg;
    case (op_reg)
      OP_ADC, OP_SBC, OP_ADD16: begin carry_flag = alu_carry_out; ovf_flag = v_calc; end
      OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_INC16: carry_flag = alu_carry_out;
      default: carry_flag = c_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg       <= 4'h0;
      a_reg        <= 16'h0000;
      b_reg        <= 16'h0000;
      c_reg        <= 1'b0;
      v_reg        <= 1'b0;
      lo_reg       <= 8'h00;
      carry_lo_reg <= 1'b0;
      rsp_result   <= 16'h0000;
      rsp_n        <= 1'b0;
      rsp_z        <= 1'b0;
      rsp_c        <= 1'b0;
      rsp_v        <= 1'b0;
      rsp_wb       <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          op_reg <= req_op;
          a_reg  <= req_a;
          b_reg  <= req_b;
          c_reg  <= req_c;
          v_reg  <= req_v;
          if (illegal_req) begin
            rsp_result <= 16'h0000;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_wb     <= 1'b0;
            rsp_err    <= 1'b1;
          end
        end
        LO: begin
          lo_reg       <= alu_Y;
          carry_lo_reg <= alu_carry_out;
          if (!is16) begin
            rsp_result <= {8'h00, alu_Y};
            rsp_n      <= alu_Y[7];
            rsp_z      <= (alu_Y == 8'h00);
            rsp_c      <= carry_flag;
            rsp_v      <= ovf_flag;
            rsp_wb     <= (op_reg != OP_CMP);
            rsp_err    <= 1'b0;
          end
        end
        HI: begin
          rsp_result <= {alu_Y, lo_reg};
          rsp_n      <= alu_Y[7];
          rsp_z      <= ({alu_Y, lo_reg} == 16'h0000);
          rsp_c      <= carry_flag;
          rsp_v      <= ovf_flag;
          rsp_wb     <= 1'b1;
          rsp_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural ALU, 6502 reference model and
// an expected-response queue checked when each response is handshaken.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_c, req_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_n, rsp_z, rsp_c, rsp_v, rsp_wb, rsp_err;
  logic [2:0]  alu_control;
  logic [7:0]  alu_AI, alu_BI;
  logic        alu_carry_in;
  logic [7:0]  alu_Y;
  logic        alu_carry_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    logic n, z, c, v, wb, err;
    int   lat;
  } exp_t;

  exp_t sb[$];

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_v(req_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_wb(rsp_wb), .rsp_err(rsp_err),
    .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
    .alu_carry_in(alu_carry_in), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out)
  );

  initial forever #5 clk = ~clk;

  // Behavioural 8-bit ALU the sequencer drives.
  always_comb begin
    alu_Y = 8'h00;
    alu_carry_out = 1'b0;
    case (alu_control)
      3'b000: {alu_carry_out, alu_Y} = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_carry_in};
      3'b001: begin alu_Y = {alu_carry_in, alu_AI[7:1]}; alu_carry_out = alu_AI[0]; end
      3'b010: alu_Y = alu_AI & alu_BI;
      3'b011: alu_Y = alu_AI | alu_BI;
      3'b100: alu_Y = alu_AI ^ alu_BI;
      default: alu_Y = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic v);
    exp_t e;
    logic [8:0]  s;
    logic [16:0] w;
    logic [7:0]  nb;
    e.res = 16'h0000; e.n = 1'b0; e.z = 1'b0; e.c = c; e.v = v;
    e.wb = 1'b1; e.err = 1'b0; e.lat = 2;
    nb = ~b[7:0];
    case (op)
      4'h0: begin s = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, c}; e.res = {8'h00, s[7:0]};
                  e.c = s[8]; e.v = (a[7] == b[7]) && (s[7] != a[7]); end
      4'h1: begin s = {1'b0, a[7:0]} + {1'b0, nb} + {8'h00, c}; e.res = {8'h00, s[7:0]};
                  e.c = s[8]; e.v = (a[7] == nb[7]) && (s[7] != a[7]); end
      4'h2: begin s = {1'b0, a[7:0]} + {1'b0, nb} + 9'd1; e.res = {8'h00, s[7:0]};
                  e.c = s[8]; e.wb = 1'b0; end
      4'h3: e.res = {8'h00, a[7:0] & b[7:0]};
      4'h4: e.res = {8'h00, a[7:0] | b[7:0]};
      4'h5: e.res = {8'h00, a[7:0] ^ b[7:0]};
      4'h6: begin e.res = {8'h00, a[6:0], 1'b0}; e.c = a[7]; end
      4'h7: begin e.res = {9'h000, a[7:1]};      e.c = a[0]; end
      4'h8: begin e.res = {8'h00, a[6:0], c};    e.c = a[7]; end
      4'h9: begin e.res = {8'h00, c, a[7:1]};    e.c = a[0]; end
      4'hA: e.res = {8'h00, a[7:0] + 8'h01};
      4'hB: e.res = {8'h00, a[7:0] - 8'h01};
      4'hC: begin w = {1'b0, a} + {1'b0, b}; e.res = w[15:0]; e.c = w[16];
                  e.v = (a[15] == b[15]) && (w[15] != a[15]); e.lat = 3; end
      4'hD: begin w = {1'b0, a} + 17'd1; e.res = w[15:0]; e.c = w[16]; e.lat = 3; end
      default: begin e.c = 1'b0; e.v = 1'b0; e.wb = 1'b0; e.err = 1'b1; e.lat = 1; end
    endcase
    if (!e.err) begin
      e.n = (op >= 4'hC) ? e.res[15] : e.res[7];
      e.z = (e.res == 16'h0000);
    end
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_before_issue", 16'(req_ready), 16'd1);
  endtask

  task automatic check_rsp(input string tag, input exp_t e);
    chk({tag, "_result"}, rsp_result, e.res);
    chk({tag, "_flags_nzcv_wb_err"}, 16'({rsp_n, rsp_z, rsp_c, rsp_v, rsp_wb, rsp_err}),
        16'({e.n, e.z, e.c, e.v, e.wb, e.err}));
  endtask

  // Issue one request, measure latency, optionally stall the response, then pop and check.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic v, input int stall);
    exp_t e;
    int   lat;
    sb.push_back(model(op, a, b, c, v));
    wait_ready();
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c; req_v = v;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    e = sb.pop_front();
    chk("latency", 16'(lat), 16'(e.lat));
    chk("rsp_valid", 16'(rsp_valid), 16'd1);
    check_rsp("rsp", e);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_op = 4'h0;
      @(posedge clk); @(negedge clk);
      chk("stall_rsp_valid", 16'(rsp_valid), 16'd1);
      chk("stall_req_ready", 16'(req_ready), 16'd0);
      check_rsp("stall", e);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("post_hs_req_ready", 16'(req_ready), 16'd1);
    $display("txn op=%h a=%h b=%h c=%b v=%b -> result=%h nzcv=%b%b%b%b wb=%b err=%b lat=%0d",
             op, a, b, c, v, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_wb, rsp_err, lat);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;
    req_c = 1'b0; req_v = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("reset_req_ready", 16'(req_ready), 16'd1);
    chk("reset_result", rsp_result, 16'h0000);
    chk("reset_flags", 16'({rsp_n, rsp_z, rsp_c, rsp_v, rsp_wb, rsp_err}), 16'd0);
    chk("reset_alu", 16'({alu_control, alu_AI, alu_carry_in}), 16'd0);
    chk("reset_alu_bi", 16'(alu_BI), 16'd0);

    // rsp_ready asserted while idle must have no effect
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_ignored", 16'(rsp_valid), 16'd0);

    send(4'h0, 16'h0050, 16'h0050, 1'b0, 1'b0, 0);  // ADC overflow
    send(4'h0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 0);  // ADC carry out
    send(4'h1, 16'h0000, 16'h0001, 1'b1, 1'b1, 0);  // SBC borrow
    send(4'h1, 16'h0080, 16'h0001, 1'b1, 1'b0, 0);  // SBC overflow
    send(4'h2, 16'h0040, 16'h0040, 1'b0, 1'b1, 0);  // CMP equal
    send(4'h2, 16'h0010, 16'h0040, 1'b1, 1'b0, 0);  // CMP less
    send(4'h9, 16'h0001, 16'h00AA, 1'b1, 1'b0, 0);  // ROR
    send(4'h7, 16'h0001, 16'h0000, 1'b1, 1'b0, 0);  // LSR
    send(4'h8, 16'h0080, 16'h0000, 1'b0, 1'b0, 0);  // ROL
    send(4'h6, 16'h00C1, 16'h0000, 1'b0, 1'b1, 0);  // ASL
    send(4'h3, 16'h00F0, 16'h000F, 1'b1, 1'b1, 0);  // AND passthrough C/V
    send(4'h4, 16'h00F0, 16'h000F, 1'b0, 1'b0, 0);  // ORA
    send(4'h5, 16'h00FF, 16'h000F, 1'b1, 1'b0, 5);  // EOR with backpressure
    send(4'hA, 16'h00FF, 16'h0000, 1'b0, 1'b1, 0);  // INC wrap
    send(4'hB, 16'h0000, 16'h0000, 1'b1, 1'b0, 0);  // DEC wrap
    send(4'hC, 16'h12FF, 16'h0001, 1'b1, 1'b0, 0);  // ADD16 carry between bytes
    send(4'hC, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);  // ADD16 overflow
    send(4'hD, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 0);  // INC16 wrap
    send(4'hF, 16'h1234, 16'h5678, 1'b1, 1'b1, 2);  // illegal with backpressure
    send(4'hE, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);  // illegal

    // Reset while the high byte of an ADD16 is in flight
    wait_ready();
    req_valid = 1'b1; req_op = 4'hC; req_a = 16'h12FF; req_b = 16'h0001; req_c = 1'b0; req_v = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("add16_lo_ai", 16'(alu_AI), 16'h00FF);
    chk("add16_lo_bi", 16'(alu_BI), 16'h0001);
    @(posedge clk); @(negedge clk);
    chk("add16_hi_ai", 16'(alu_AI), 16'h0012);
    chk("add16_hi_cin", 16'(alu_carry_in), 16'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("abort_req_ready", 16'(req_ready), 16'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_no_response", 16'(rsp_valid), 16'd0);
    $display("txn reset abort of ADD16 -> rsp_valid=%b req_ready=%b", rsp_valid, req_ready);

    send(4'h0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);  // ADC after abort
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that owns the 8-bit ALU and sequences 6502-style operations onto it: operand selection, carry-in steering, SBC/CMP operand inversion, shift/rotate mapping, and two-pass 16-bit add/increment for address arithmetic. Sits between the instruction decoder (request side) and the ALU (combinational datapath). Accepts one request at a time via valid/ready and returns the result plus N/Z/C/V via valid/ready. Decimal mode is not supported.

Parameters:
ALU_ADD, 3'b000, ALU control code for add
ALU_SR, 3'b001, ALU control code for shift right
ALU_AND, 3'b010, ALU control code for AND
ALU_OR, 3'b011, ALU control code for OR
ALU_XOR, 3'b100, ALU control code for XOR

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (high only in IDLE)
req_op  in  4  0 ADC,1 SBC,2 CMP,3 AND,4 ORA,5 EOR,6 ASL,7 LSR,8 ROL,9 ROR,A INC,B DEC,C ADD16,D INC16,E/F illegal
req_a  in  16  operand A (8-bit ops use [7:0])
req_b  in  16  operand B (8-bit ops use [7:0]; ignored by shifts/INC/DEC/INC16)
req_c  in  1  incoming carry flag
req_v  in  1  incoming overflow flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  result ([15:8]=0 for 8-bit ops)
rsp_n, rsp_z, rsp_c, rsp_v  out  1 each  resulting flags
rsp_wb  out  1  1 = result written back (0 for CMP and illegal ops)
rsp_err  out  1  illegal opcode
alu_control  out  3  to ALU
alu_AI, alu_BI  out  8 each  to ALU
alu_carry_in  out  1  to ALU
alu_Y  in  8  ALU result
alu_carry_out  in  1  ALU carry

Behaviour:
- States: IDLE, LO, HI, DONE. Reset (synchronous): state=IDLE; rsp_* all 0; latched operands 0; ALU ports driven ALU_ADD, 0, 0, 0.
- IDLE: req_ready=1. On req_valid: latch op/a/b/c/v -> LO. Illegal op: -> DONE directly, rsp_err=1, result 0, all flags 0, rsp_wb=0.
- LO: drive ALU combinationally from latched operands; capture alu_Y/alu_carry_out into low-result/carry registers. ADD16/INC16 -> HI; otherwise -> DONE.
- HI: high byte, carry_in = carry captured in LO; capture -> DONE.
- DONE: rsp_valid=1; all rsp_* held stable until rsp_ready; on handshake -> IDLE. req_ready=0 throughout LO/HI/DONE.
- Latency: rsp_valid rises 2 cycles after accept edge (8-bit), 3 cycles (16-bit), 1 cycle (illegal). Best-case throughput: 1 op / 3 cycles (8-bit).
- ALU mapping (AI, BI, control, carry_in): ADC A,B,ADD,c; SBC A,~B,ADD,c; CMP A,~B,ADD,1; AND/ORA/EOR A,B,AND/OR/XOR,0; ASL A,A,ADD,0; ROL A,A,ADD,c; LSR A,-,SR,0; ROR A,-,SR,c; INC A,00,ADD,1; DEC A,FF,ADD,0; ADD16 lo A_lo,B_lo,ADD,0 / hi A_hi,B_hi,ADD,carry_lo; INC16 lo A_lo,00,ADD,1 / hi A_hi,00,ADD,carry_lo. Unused BI driven 0.
- Flags: N = result bit 7 (bit 15 for 16-bit); Z = full result == 0 (16-bit compare for 16-bit ops); C = final alu_carry_out for ADC/SBC/CMP/shifts/rotates/ADD16/INC16, else req_c passthrough; V computed locally for ADC/SBC/ADD16 as (AI[7] XNOR BI[7]) AND (AI[7] XOR Y[7]) on the operands actually driven (final pass), else req_v passthrough. The ALU overflow output is not consumed.
- CMP: rsp_result = difference, rsp_wb=0, V = req_v.
- Reset asserted in any state: aborts in-flight op next edge, no response emitted.
- rsp_ready high outside DONE: ignored.

Test Plan:
- ADC A=0x50 B=0x50 c=0 -> result 0x50+0x50=0xA0, N=1 Z=0 C=0 V=1, wb=1; rsp_valid exactly 2 cycles after accept.
- SBC A=0x00 B=0x01 c=1 -> 0xFF, N=1 C=0 V=0; CMP A=0x40 B=0x40 -> Z=1 C=1 N=0, wb=0, V=req_v.
- ROR A=0x01 c=1 -> 0x80, C=1 N=1; LSR A=0x01 -> 0x00, Z=1 C=1; ROL A=0x80 c=0 -> 0x00, Z=1 C=1; AND 0xF0&0x0F with c=1,v=1 -> 0x00, Z=1, C=1 V=1 passthrough.
- ADD16 0x12FF+0x0001 -> 0x1300, C=0 Z=0 N=0, latency 3; INC16 0xFFFF -> 0x0000, Z=1 C=1; DEC 0x00 -> 0xFF N=1, C=req_c.
- Backpressure: rsp_ready low 5 cycles in DONE -> all rsp_* stable, req_ready=0, new req_valid ignored; illegal op 0xF -> rsp_err=1, result 0, flags 0, latency 1.
- Reset pulsed during HI of ADD16 -> next cycle IDLE, rsp_valid=0, req_ready=1; following ADC 0x01+0x01 returns 0x02 normally.
